// File: rtl/ex_result_buffer_pkg.sv
// Shared constants and types for the execute-stage result buffer.
package ex_result_buffer_pkg;

  localparam int unsigned EX_WORD_WIDTH = 32;
  localparam int unsigned EX_DEF_DEPTH  = 8;

  // Saturating increment against an upper bound.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : 8'(v + 8'd1);
  endfunction

endpackage

// File: rtl/ex_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head.
module ex_sync_fifo
  import ex_result_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = EX_WORD_WIDTH,
  parameter int unsigned DEPTH      = EX_DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         rvalid,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, next_rd_ptr;
  logic [CNT_WIDTH-1:0]  next_count;
  logic                  head_bypass;

  assign full  = (count == CNT_WIDTH'(DEPTH));
  assign empty = (count == '0);

  // Next head comes from the word being written when it lands at the next read slot.
  always_comb begin
    next_count  = count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    next_rd_ptr = rd_ptr + ADDR_WIDTH'(pop);
    head_bypass = push && (wr_ptr == next_rd_ptr);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      rd_ptr <= next_rd_ptr;
      count  <= next_count;
      rvalid <= (next_count != '0);
      if (next_count != '0) rdata <= head_bypass ? wdata : mem[next_rd_ptr];
    end
  end

endmodule

// File: rtl/ex_result_buffer.sv
// Result FIFO behind the CORDIC execute stage with issue credit, in-flight tracking and sticky errors.
module ex_result_buffer
  import ex_result_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = EX_WORD_WIDTH,
  parameter int unsigned DEPTH      = EX_DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_credit,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [CNT_WIDTH-1:0]  inflight,
  output logic                  overflow,
  output logic                  proto_err,
  input  logic                  clear_err
);

  logic                 pop, push, drop, full, empty;
  logic                 proto_set;
  logic [CNT_WIDTH-1:0] inflight_nxt;
  logic [CNT_WIDTH:0]   occupied;

  assign pop  = m_valid && m_ready;
  assign push = res_valid && (!full || pop);
  assign drop = res_valid && full && !pop;

  // Credit counts stored plus outstanding words; a same-cycle pop is deliberately ignored.
  assign occupied     = (CNT_WIDTH+1)'(count) + (CNT_WIDTH+1)'(inflight);
  assign issue_credit = (occupied < (CNT_WIDTH+1)'(DEPTH));

  always_comb begin
    inflight_nxt = inflight;
    proto_set    = (res_valid && (inflight == '0)) || (issue_valid && !issue_credit);
    if (issue_valid && !res_valid) begin
      if (inflight != CNT_WIDTH'(DEPTH)) inflight_nxt = inflight + CNT_WIDTH'(1);
    end else if (res_valid && !issue_valid) begin
      if (inflight != '0) inflight_nxt = inflight - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight  <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      if (drop)           overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (proto_set)      proto_err <= 1'b1;
      else if (clear_err) proto_err <= 1'b0;
    end
  end

  ex_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .wdata  (res_data),
    .pop    (pop),
    .rdata  (m_data),
    .rvalid (m_valid),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

endmodule

// File: tb/tb_ex_result_buffer.sv
// Scenario and randomized bench for ex_result_buffer against a queue-based reference model.
module tb_ex_result_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, res_valid, m_ready, clear_err;
  logic        issue_credit, m_valid, overflow, proto_err;
  logic [31:0] res_data, m_data;
  logic [3:0]  count, inflight;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  int          minfl;
  bit          movf, mperr;

  always #5 clk = ~clk;

  ex_result_buffer dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_credit(issue_credit),
    .res_data(res_data), .res_valid(res_valid), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .count(count), .inflight(inflight), .overflow(overflow),
    .proto_err(proto_err), .clear_err(clear_err)
  );

  task automatic model_reset();
    mq.delete();
    minfl = 0;
    movf  = 0;
    mperr = 0;
  endtask

  // One clock: drive inputs, advance the reference model, return at the next falling edge.
  task automatic cycle(input bit iv, input bit rv, input logic [31:0] d, input bit rdy, input bit clr);
    bit credit, pop, full, push, pset, oset;
    issue_valid = iv; res_valid = rv; res_data = d; m_ready = rdy; clear_err = clr;
    credit = (mq.size() + minfl) < 8;
    pop    = (mq.size() > 0) && rdy;
    full   = (mq.size() == 8);
    push   = rv && (!full || pop);
    pset   = (rv && minfl == 0) || (iv && !credit);
    oset   = rv && full && !pop;
    @(posedge clk);
    if (iv && !rv && minfl < 8) minfl++;
    else if (rv && !iv && minfl > 0) minfl--;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(d);
    if (oset) movf = 1; else if (clr) movf = 0;
    if (pset) mperr = 1; else if (clr) mperr = 0;
    @(negedge clk);
    issue_valid = 0; res_valid = 0; clear_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 4'd0)      begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (inflight !== 4'd0)   begin errors++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
    checks++; if (m_valid !== 1'b0)    begin errors++; $display("FAIL reset_m_valid got %0b exp 0", m_valid); end
    checks++; if (m_data !== 32'h0)    begin errors++; $display("FAIL reset_m_data got %0h exp 0", m_data); end
    checks++; if (issue_credit !== 1'b1) begin errors++; $display("FAIL reset_credit got %0b exp 1", issue_credit); end
    checks++; if (overflow !== 1'b0 || proto_err !== 1'b0)
      begin errors++; $display("FAIL reset_flags got %0b%0b exp 00", overflow, proto_err); end
  endtask

  task automatic test_in_order();
    logic [31:0] words [3];
    words[0] = 32'h00010002; words[1] = 32'h00030004; words[2] = 32'h00050006;
    repeat (3) cycle(1, 0, 0, 1, 0);
    checks++; if (inflight !== 4'd3) begin errors++; $display("FAIL order_inflight got %0d exp 3", inflight); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, words[i], 1, 0);
      checks++; if (m_valid !== 1'b1 || m_data !== words[i])
        begin errors++; $display("FAIL order_word%0d got v=%0b %0h exp v=1 %0h", i, m_valid, m_data, words[i]); end
    end
    cycle(0, 0, 0, 1, 0);
    checks++; if (count !== 4'd0 || m_valid !== 1'b0)
      begin errors++; $display("FAIL order_drain got count=%0d v=%0b exp 0 0", count, m_valid); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL order_proto got %0b exp 0", proto_err); end
  endtask

  task automatic test_fill();
    logic [31:0] first;
    first = 32'hA5A50000;
    repeat (8) cycle(1, 0, 0, 0, 0);
    checks++; if (issue_credit !== 1'b0) begin errors++; $display("FAIL fill_credit_issued got %0b exp 0", issue_credit); end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, first + 32'(i), 0, 0);
      checks++; if (m_data !== first) begin errors++; $display("FAIL fill_head_steady got %0h exp %0h", m_data, first); end
    end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", count); end
    checks++; if (issue_credit !== 1'b0 || overflow !== 1'b0)
      begin errors++; $display("FAIL fill_credit_ovf got %0b %0b exp 0 0", issue_credit, overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_head;
    cycle(0, 1, 32'h11112222, 1, 0);
    exp_head = mq[0];
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fullpp_count got %0d exp 8", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got %0b exp 0", overflow); end
    checks++; if (m_data !== exp_head) begin errors++; $display("FAIL fullpp_head got %0h exp %0h", m_data, exp_head); end
  endtask

  task automatic test_drop();
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 32'hDEADBEEF, 0, 0);
    checks++; if (overflow !== 1'b1 || count !== 4'd8)
      begin errors++; $display("FAIL drop got ovf=%0b count=%0d exp 1 8", overflow, count); end
    cycle(0, 1, 32'hDEADBEEF, 0, 1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_set_wins got %0b exp 1", overflow); end
    cycle(0, 0, 0, 0, 1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL drop_clear got %0b exp 0", overflow); end
    repeat (8) cycle(0, 0, 0, 1, 0);
    checks++; if (count !== 4'(mq.size())) begin errors++; $display("FAIL drop_drain got %0d exp %0d", count, mq.size()); end
  endtask

  task automatic test_proto();
    do_reset();
    cycle(0, 1, 32'h12345678, 1, 0);
    checks++; if (proto_err !== 1'b1 || inflight !== 4'd0)
      begin errors++; $display("FAIL proto_res got err=%0b infl=%0d exp 1 0", proto_err, inflight); end
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h12345678)
      begin errors++; $display("FAIL proto_pushed got v=%0b %0h exp 1 12345678", m_valid, m_data); end
    cycle(0, 0, 0, 1, 1);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clear got %0b exp 0", proto_err); end
    repeat (8) cycle(1, 0, 0, 0, 0);
    checks++; if (proto_err !== 1'b0 || issue_credit !== 1'b0)
      begin errors++; $display("FAIL proto_credit got err=%0b cr=%0b exp 0 0", proto_err, issue_credit); end
    cycle(1, 0, 0, 0, 0);
    checks++; if (proto_err !== 1'b1 || inflight !== 4'd8)
      begin errors++; $display("FAIL proto_nocredit got err=%0b infl=%0d exp 1 8", proto_err, inflight); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (7) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 32'h100 + 32'(i), 0, 0);
    checks++; if (count !== 4'd5 || inflight !== 4'd2)
      begin errors++; $display("FAIL midrst_pre got count=%0d infl=%0d exp 5 2", count, inflight); end
    #2 reset = 0;
    model_reset();
    #1;
    checks++; if (count !== 4'd0 || inflight !== 4'd0 || m_valid !== 1'b0 || m_data !== 32'h0)
      begin errors++; $display("FAIL midrst_async got c=%0d i=%0d v=%0b d=%0h exp 0 0 0 0", count, inflight, m_valid, m_data); end
    checks++; if (overflow !== 1'b0 || proto_err !== 1'b0 || issue_credit !== 1'b1)
      begin errors++; $display("FAIL midrst_flags got o=%0b p=%0b cr=%0b exp 0 0 1", overflow, proto_err, issue_credit); end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++; if (issue_credit !== 1'b1) begin errors++; $display("FAIL midrst_release_credit got %0b exp 1", issue_credit); end
  endtask

  task automatic test_random();
    bit iv, rv, rdy, clr, credit;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      credit = (mq.size() + minfl) < 8;
      iv  = credit ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      rv  = (minfl > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      cycle(iv, rv, $urandom, rdy, clr);
      checks++; if (count !== 4'(mq.size()))
        begin errors++; $display("FAIL rand_count n=%0d got %0d exp %0d", n, count, mq.size()); end
      checks++; if (inflight !== 4'(minfl))
        begin errors++; $display("FAIL rand_inflight n=%0d got %0d exp %0d", n, inflight, minfl); end
      checks++; if (m_valid !== (mq.size() > 0))
        begin errors++; $display("FAIL rand_m_valid n=%0d got %0b exp %0b", n, m_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++; if (m_data !== mq[0])
          begin errors++; $display("FAIL rand_m_data n=%0d got %0h exp %0h", n, m_data, mq[0]); end
      end
      checks++; if (issue_credit !== ((mq.size() + minfl) < 8))
        begin errors++; $display("FAIL rand_credit n=%0d got %0b", n, issue_credit); end
      checks++; if (overflow !== movf || proto_err !== mperr)
        begin errors++; $display("FAIL rand_flags n=%0d got %0b%0b exp %0b%0b", n, overflow, proto_err, movf, mperr); end
    end
  endtask

  initial begin
    reset = 1; issue_valid = 0; res_valid = 0; res_data = 0; m_ready = 0; clear_err = 0;
    model_reset();
    test_reset();
    test_in_order();
    test_fill();
    test_full_push_pop();
    test_drop();
    test_proto();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
